hc595_frame_arbiter: RTL and testbench

- Shares the single 74HC595 shift-register chain (segments + anodes, 16-bit frame) between two frame sources, e.g. the hex display scanner and a status/message generator.
- Grants one 16-bit frame at a time, round-robin, and hands it to the shift controller over a valid/ready handshake.
- Waits for the controller's latch-done pulse, then signals completion to the owner.
- A watchdog guards against a stalled shifter.

---
 rtl/hc595_frame_arbiter.sv | 158 +++++++++++++++
 tb/tb_hc595_frame_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_frame_arbiter.sv
// Round-robin arbiter handing 16-bit frames from two sources to the 74HC595 shift controller.
// Optional build macro ARB_LOCK_EN: lets the last-served requester hold the grant via i_lock.
module hc595_frame_arbiter #(
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    i_req_vld,
   input  logic [DW-1:0] i_req_data0,
   input  logic [DW-1:0] i_req_data1,
   output logic [1:0]    o_req_rdy,
   output logic [1:0]    o_req_done,
   input  logic [1:0]    i_lock,
   output logic [DW-1:0] o_sh_data,
   output logic          o_sh_vld,
   input  logic          i_sh_rdy,
   input  logic          i_sh_done,
   output logic          o_busy,
   output logic          o_err,
   input  logic          i_err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] frame_q, frame_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic [TW-1:0] wdog_q, wdog_d;
   logic          err_q, err_d;
   logic [1:0]    done_q, done_d;
   logic          sh_vld_q, sh_vld_d;

   logic          sel_any;
   logic          sel_idx;

   // Requester selection: a lone valid wins, a tie goes to the one not served last.
   always_comb begin
      sel_any = |i_req_vld;
      if (i_req_vld == 2'b11) begin
         sel_idx = ~last_q;
      end else begin
         sel_idx = i_req_vld[1];
      end
`ifdef ARB_LOCK_EN
      if (i_lock[last_q] && i_req_vld[last_q]) begin
         sel_idx = last_q;
      end
`endif
   end

`ifndef ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^i_lock;
`endif

   always_comb begin
      o_req_rdy = 2'b00;
      if (state_q == ST_IDLE && sel_any) begin
         o_req_rdy = sel_idx ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      owner_d  = owner_q;
      last_d   = last_q;
      wdog_d   = wdog_q;
      err_d    = err_q;
      done_d   = '0;
      sh_vld_d = sh_vld_q;

      // Clear first so a same-cycle watchdog abort below overrides it.
      if (i_err_clr) begin
         err_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (sel_any) begin
               frame_d  = sel_idx ? i_req_data1 : i_req_data0;
               owner_d  = sel_idx;
               sh_vld_d = 1'b1;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (i_sh_rdy) begin
               sh_vld_d = 1'b0;
               wdog_d   = '0;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_sh_done) begin
               done_d  = owner_q ? 2'b10 : 2'b01;
               last_d  = owner_q;
               state_d = ST_IDLE;
            end else if (wdog_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               last_d  = owner_q;
               state_d = ST_IDLE;
            end else begin
               wdog_d = wdog_q + TW'(1);
            end
         end
         default: begin
            sh_vld_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         frame_q  <= '0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         wdog_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= '0;
         sh_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         wdog_q   <= wdog_d;
         err_q    <= err_d;
         done_q   <= done_d;
         sh_vld_q <= sh_vld_d;
      end
   end

   assign o_sh_data  = frame_q;
   assign o_sh_vld   = sh_vld_q;
   assign o_req_done = done_q;
   assign o_err      = err_q;
   assign o_busy     = (state_q != ST_IDLE);

   a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(o_req_rdy));
   a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(o_req_done));
   a_frame_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (o_sh_vld && !i_sh_rdy) |=> (o_sh_vld && $stable(o_sh_data)));
   a_wdog_range: assert property (@(posedge clk) disable iff (!rst_n)
      wdog_q <= TW'(TIMEOUT - 1));

endmodule

// File: tb/tb_hc595_frame_arbiter.sv
// Self-checking bench for hc595_frame_arbiter: vector table, directed corner sequences, random vs. model.
module tb_hc595_frame_arbiter;

   localparam int unsigned DW  = 16;
   localparam int unsigned TMO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    i_req_vld;
   logic [DW-1:0] i_req_data0, i_req_data1;
   logic [1:0]    o_req_rdy, o_req_done, i_lock;
   logic [DW-1:0] o_sh_data;
   logic          o_sh_vld, i_sh_rdy, i_sh_done, o_busy, o_err, i_err_clr;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int          last_grant = 0;

   always #5 clk = ~clk;

   hc595_frame_arbiter #(.DW(DW), .TIMEOUT(TMO), .TW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_vld(i_req_vld), .i_req_data0(i_req_data0), .i_req_data1(i_req_data1),
      .o_req_rdy(o_req_rdy), .o_req_done(o_req_done), .i_lock(i_lock),
      .o_sh_data(o_sh_data), .o_sh_vld(o_sh_vld), .i_sh_rdy(i_sh_rdy),
      .i_sh_done(i_sh_done), .o_busy(o_busy), .o_err(o_err), .i_err_clr(i_err_clr)
   );

   typedef struct {
      logic [1:0]  vld;
      logic [15:0] d0, d1;
      logic        sh_rdy, sh_done, clr;
      logic [1:0]  e_rdy;
      logic        e_vld;
      logic [15:0] e_data;
      logic [1:0]  e_done;
      logic        e_busy, e_err;
   } vec_t;

   localparam int NV = 16;
   vec_t tv[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      i_req_vld = '0; i_req_data0 = '0; i_req_data1 = '0; i_lock = '0;
      i_sh_rdy = 1'b0; i_sh_done = 1'b0; i_err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Both sources always valid, shifter always ready and done; exp_own[k] = expected k-th winner.
   task automatic grant_seq(input logic [1:0] lock, input int unsigned n, input logic [7:0] exp_own);
      int unsigned got = 0;
      for (int unsigned c = 0; c < n * 6 && got < n; c++) begin
         @(negedge clk);
         i_req_vld = 2'b11; i_req_data0 = 16'h1111; i_req_data1 = 16'h2222;
         i_lock = lock; i_sh_rdy = 1'b1; i_sh_done = 1'b1;
         #1;
         chk("rdy_not_both", 32'(o_req_rdy == 2'b11), 32'd0);
         if (o_req_rdy != 2'b00) begin
            last_grant = int'(o_req_rdy[1]);
            chk($sformatf("grant%0d", got), 32'(o_req_rdy), exp_own[got] ? 32'd2 : 32'd1);
            got++;
         end
         if (o_sh_vld) chk("grant_sh_data", 32'(o_sh_data), last_grant != 0 ? 32'h2222 : 32'h1111);
      end
      chk("grant_count", got, n);
   endtask

   function automatic int pick(input logic [1:0] v, input int last, input logic [1:0] lk);
      bit lock_on;
`ifdef ARB_LOCK_EN
      lock_on = 1'b1;
`else
      lock_on = 1'b0;
`endif
      if (lock_on && lk[last] && v[last]) return last;
      if (v == 2'b11) return 1 - last;
      return v[1] ? 1 : 0;
   endfunction

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          cnt;
      int          m_last, m_owner, m_age, w;
      bit          m_has, m_shifted, m_err, set_err;
      logic [15:0] m_frame;
      logic [1:0]  m_done, nd, exp_rdy;

      // {vld, d0, d1, sh_rdy, sh_done, clr | rdy, sh_vld, sh_data, done, busy, err}
      tv[0]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0};
      tv[1]  = '{2'b01, 16'hA5F1, 16'h5A5A, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0};
      tv[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 16'hA5F1, 2'b00, 1'b1, 1'b0};
      tv[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'hA5F1, 2'b00, 1'b1, 1'b0};
      tv[4]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'hA5F1, 2'b00, 1'b1, 1'b0};
      tv[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'hA5F1, 2'b00, 1'b1, 1'b0};
      tv[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'hA5F1, 2'b00, 1'b1, 1'b0};
      tv[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'hA5F1, 2'b01, 1'b0, 1'b0};
      tv[8]  = '{2'b10, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 16'hA5F1, 2'b00, 1'b0, 1'b0};
      tv[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h1234, 2'b00, 1'b1, 1'b0};
      tv[10] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 16'h1234, 2'b00, 1'b1, 1'b0};
      tv[11] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 16'h1234, 2'b00, 1'b1, 1'b0};
      tv[12] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h1234, 2'b00, 1'b1, 1'b0};
      tv[13] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h1234, 2'b10, 1'b0, 1'b0};
      tv[14] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 16'h1234, 2'b00, 1'b0, 1'b0};
      tv[15] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h1234, 2'b00, 1'b0, 1'b0};

      idle_inputs();
      rst_n = 1'b0;
      do_reset();

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         i_req_vld = tv[i].vld; i_req_data0 = tv[i].d0; i_req_data1 = tv[i].d1;
         i_sh_rdy = tv[i].sh_rdy; i_sh_done = tv[i].sh_done; i_err_clr = tv[i].clr;
         #1;
         chk($sformatf("vec%0d_rdy", i),  32'(o_req_rdy),  32'(tv[i].e_rdy));
         chk($sformatf("vec%0d_vld", i),  32'(o_sh_vld),   32'(tv[i].e_vld));
         chk($sformatf("vec%0d_data", i), 32'(o_sh_data),  32'(tv[i].e_data));
         chk($sformatf("vec%0d_done", i), 32'(o_req_done), 32'(tv[i].e_done));
         chk($sformatf("vec%0d_busy", i), 32'(o_busy),     32'(tv[i].e_busy));
         chk($sformatf("vec%0d_err", i),  32'(o_err),      32'(tv[i].e_err));
      end

      // Round-robin with both sources continuously valid: 0,1,0,1,0,1.
      do_reset();
      grant_seq(2'b00, 6, 8'b0010_1010);

      // Shifter stalled 20 cycles in SEND: frame held, no watchdog.
      do_reset();
      @(negedge clk); i_req_vld = 2'b01; i_req_data0 = 16'hBEEF; i_sh_rdy = 1'b0; #1;
      chk("stall_rdy", 32'(o_req_rdy), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); i_req_vld = 2'b00; i_sh_rdy = 1'b0; #1;
         chk("stall_vld", 32'(o_sh_vld), 32'd1);
         chk("stall_data", 32'(o_sh_data), 32'hBEEF);
         chk("stall_err", 32'(o_err), 32'd0);
      end
      @(negedge clk); i_sh_rdy = 1'b1; #1;
      chk("stall_accept_vld", 32'(o_sh_vld), 32'd1);
      @(negedge clk); i_sh_rdy = 1'b0; i_sh_done = 1'b1; #1;
      chk("stall_wait_vld", 32'(o_sh_vld), 32'd0);
      chk("stall_wait_busy", 32'(o_busy), 32'd1);
      @(negedge clk); i_sh_done = 1'b0; #1;
      chk("stall_done", 32'(o_req_done), 32'd1);
      chk("stall_idle", 32'(o_busy), 32'd0);

      // Watchdog abort; err_clr held on the abort cycle to show set beats clear.
      do_reset();
      @(negedge clk); i_req_vld = 2'b01; i_req_data0 = 16'hC0DE; i_sh_rdy = 1'b1; #1;
      chk("to_rdy", 32'(o_req_rdy), 32'd1);
      @(negedge clk); i_req_vld = 2'b00; #1;
      chk("to_send", 32'(o_sh_vld), 32'd1);
      cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk); i_err_clr = (k == TMO); #1;
         if (o_err) break;
         cnt++;
         chk("to_no_done", 32'(o_req_done), 32'd0);
      end
      i_err_clr = 1'b0;
      chk("to_latency", cnt, TMO);
      chk("to_err", 32'(o_err), 32'd1);
      chk("to_idle", 32'(o_busy), 32'd0);
      chk("to_done_none", 32'(o_req_done), 32'd0);
      @(negedge clk); i_req_vld = 2'b10; i_req_data1 = 16'h0BAD; #1;
      chk("to_next_rdy", 32'(o_req_rdy), 32'd2);
      @(negedge clk); i_req_vld = 2'b00; #1;
      chk("to_next_data", 32'(o_sh_data), 32'h0BAD);
      @(negedge clk); i_sh_done = 1'b1; #1;
      chk("to_next_busy", 32'(o_busy), 32'd1);
      @(negedge clk); i_sh_done = 1'b0; #1;
      chk("to_next_done", 32'(o_req_done), 32'd2);
      chk("to_err_sticky", 32'(o_err), 32'd1);
      @(negedge clk); i_err_clr = 1'b1; #1;
      @(negedge clk); i_err_clr = 1'b0; #1;
      chk("to_err_clr", 32'(o_err), 32'd0);
      // Done on the last allowed waiting cycle wins over the abort.
      @(negedge clk); i_req_vld = 2'b01; i_req_data0 = 16'h1357; #1;
      chk("co_rdy", 32'(o_req_rdy), 32'd1);
      @(negedge clk); i_req_vld = 2'b00; #1;
      for (int k = 1; k < TMO; k++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); i_sh_done = 1'b1; #1;
      chk("co_busy", 32'(o_busy), 32'd1);
      @(negedge clk); i_sh_done = 1'b0; #1;
      chk("co_done", 32'(o_req_done), 32'd1);
      chk("co_err", 32'(o_err), 32'd0);
      chk("co_idle", 32'(o_busy), 32'd0);

      // Reset during WAIT with done asserted: frame dropped silently.
      do_reset();
      @(negedge clk); i_req_vld = 2'b10; i_req_data1 = 16'h7777; i_sh_rdy = 1'b1; #1;
      chk("rw_rdy", 32'(o_req_rdy), 32'd2);
      @(negedge clk); i_req_vld = 2'b00; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("rw_in_wait", 32'(o_busy), 32'd1);
      @(negedge clk); rst_n = 1'b0; i_sh_done = 1'b1; #1;
      @(negedge clk); rst_n = 1'b1; i_sh_done = 1'b0;
      i_req_vld = 2'b11; i_req_data0 = 16'h0001; i_req_data1 = 16'h0002; #1;
      chk("rw_busy", 32'(o_busy), 32'd0);
      chk("rw_vld", 32'(o_sh_vld), 32'd0);
      chk("rw_err", 32'(o_err), 32'd0);
      chk("rw_done", 32'(o_req_done), 32'd0);
      chk("rw_data", 32'(o_sh_data), 32'd0);
      chk("rw_tie_req0", 32'(o_req_rdy), 32'd1);

      do_reset();
`ifdef ARB_LOCK_EN
      grant_seq(2'b01, 3, 8'b0000_0000);
      grant_seq(2'b00, 1, 8'b0000_0001);
`else
      grant_seq(2'b01, 4, 8'b0000_1010);
`endif

      // Random traffic against a transaction-level model.
      do_reset();
      m_last = 1; m_owner = 0; m_age = 0; m_has = 0; m_shifted = 0; m_err = 0;
      m_frame = '0; m_done = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rst_n       = ($urandom_range(0, 63) != 0);
         i_req_vld   = 2'($urandom);
         i_req_data0 = 16'($urandom);
         i_req_data1 = 16'($urandom);
         i_lock      = 2'($urandom);
         i_sh_rdy    = 1'($urandom_range(0, 1));
         i_sh_done   = ($urandom_range(0, 4) == 0);
         i_err_clr   = ($urandom_range(0, 7) == 0);
         #1;
         w = pick(i_req_vld, m_last, i_lock);
         exp_rdy = (!m_has && i_req_vld != 2'b00) ? (w == 1 ? 2'b10 : 2'b01) : 2'b00;
         chk("rnd_rdy",  32'(o_req_rdy),  32'(exp_rdy));
         chk("rnd_vld",  32'(o_sh_vld),   32'(m_has && !m_shifted));
         chk("rnd_data", 32'(o_sh_data),  32'(m_frame));
         chk("rnd_done", 32'(o_req_done), 32'(m_done));
         chk("rnd_busy", 32'(o_busy),     32'(m_has));
         chk("rnd_err",  32'(o_err),      32'(m_err));
         if (!rst_n) begin
            m_last = 1; m_has = 0; m_shifted = 0; m_err = 0; m_frame = '0; m_done = '0;
         end else begin
            nd = 2'b00;
            set_err = 1'b0;
            if (!m_has) begin
               if (i_req_vld != 2'b00) begin
                  m_has = 1; m_shifted = 0; m_owner = w;
                  m_frame = (w == 1) ? i_req_data1 : i_req_data0;
               end
            end else if (!m_shifted) begin
               if (i_sh_rdy) begin
                  m_shifted = 1; m_age = 0;
               end
            end else begin
               m_age++;
               if (i_sh_done) begin
                  nd[m_owner] = 1'b1; m_last = m_owner; m_has = 0;
               end else if (m_age == TMO) begin
                  set_err = 1'b1; m_last = m_owner; m_has = 0;
               end
            end
            if (set_err) m_err = 1'b1;
            else if (i_err_clr) m_err = 1'b0;
            m_done = nd;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
